// File: rtl/hyperbus_pkg.sv
// Shared encodings for the Hyperbus burst FIFO bridge.
package hyperbus_pkg;

    localparam int unsigned STATE_W = 3;

    // Command direction bit as stored in the command FIFO
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // One-hot FSM state encodings
    localparam logic [STATE_W-1:0] ST_IDLE = 3'b001;
    localparam logic [STATE_W-1:0] ST_RD   = 3'b010;
    localparam logic [STATE_W-1:0] ST_WR   = 3'b100;

endpackage

// File: rtl/hyperbus_sync_fifo.sv
// Single-clock first-word fall-through FIFO with a one-ahead peek port.
module hyperbus_sync_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      data_o,
    output logic [WIDTH-1:0]      next_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_nxt;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rd_nxt  = rd_ptr_q + DEPTH_LOG2'(1);
    assign data_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_nxt];

    // Pointer and occupancy next-state, including simultaneous push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop_ok)  rd_ptr_d = rd_nxt;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the FIFO without clearing storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/hyperbus_burst_fifo.sv
// Burst command bridge: serialises FIFO words into Hyperbus beats and back.
module hyperbus_burst_fifo
    import hyperbus_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned HBUS_DATA_WIDTH = 16,
    parameter int unsigned HBUS_ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2      = 3,
    parameter int unsigned BURST_WIDTH     = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
    input  logic [BURST_WIDTH-1:0]     cmd_len,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [FIFO_DATA_WIDTH-1:0] tx_dat,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [FIFO_DATA_WIDTH-1:0] rx_dat,
    output logic                       idle,
    output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    output logic                       hbus_rrq,
    output logic                       hbus_wrq,
    input  logic                       hbus_ready,
    input  logic                       hbus_valid,
    input  logic                       hbus_busy
);

    localparam int unsigned CYCLES  = FIFO_DATA_WIDTH / HBUS_DATA_WIDTH;
    localparam int unsigned BEAT_W  = $clog2(CYCLES + 1);
    localparam int unsigned WORDS_W = BURST_WIDTH + 1;
    localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CMD_W   = 1 + HBUS_ADDR_WIDTH + BURST_WIDTH;

    logic [STATE_W-1:0]         state_q, state_d;
    logic [HBUS_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [FIFO_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [FIFO_DATA_WIDTH-1:0] asm_q, asm_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [WORDS_W-1:0]         words_left_q, words_left_d;

    logic [CMD_W-1:0]           cmd_head, cmd_next;
    logic                       cmd_full, cmd_empty;
    logic [CNT_W-1:0]           cmd_count;
    logic [FIFO_DATA_WIDTH-1:0] tx_head, tx_next, rx_next;
    logic                       tx_full, tx_empty, rx_full, rx_empty;
    logic [CNT_W-1:0]           tx_count, rx_count, rx_free;

    logic                       head_we;
    logic [HBUS_ADDR_WIDTH-1:0] head_adr;
    logic [BURST_WIDTH-1:0]     head_len;
    logic [WORDS_W-1:0]         head_n;
    logic                       launch_c;
    logic                       last_beat, last_word;
    logic                       cmd_pop, tx_pop, rx_push, rx_pop;
    logic                       unused_c;

    assign head_we   = cmd_head[CMD_W-1];
    assign head_adr  = cmd_head[CMD_W-2 -: HBUS_ADDR_WIDTH];
    assign head_len  = cmd_head[BURST_WIDTH-1:0];
    assign head_n    = WORDS_W'(head_len) + WORDS_W'(1);
    assign rx_free   = CNT_W'(DEPTH) - rx_count;
    assign last_beat = (beat_q == BEAT_W'(1));
    assign last_word = (words_left_q == WORDS_W'(1));

    // Launch only when the whole burst's data or space is already reserved
    assign launch_c = !cmd_empty && !hbus_busy &&
                      ((head_we == CMD_WRITE) ? (tx_count >= CNT_W'(head_n))
                                              : (rx_free  >= CNT_W'(head_n)));

    assign cmd_ready  = !cmd_full;
    assign tx_ready   = !tx_full;
    assign rx_valid   = !rx_empty;
    assign rx_pop     = rx_valid && rx_ready;
    assign idle       = (state_q == ST_IDLE) && cmd_empty;
    assign hbus_wrq   = (state_q == ST_WR);
    assign hbus_rrq   = (state_q == ST_RD);
    assign hbus_adr_o = adr_q;
    assign hbus_dat_o = shift_q[FIFO_DATA_WIDTH-1 -: HBUS_DATA_WIDTH];
    assign unused_c   = ^{cmd_next, cmd_count, rx_next, tx_empty, rx_full};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch_c) state_d = (head_we == CMD_WRITE) ? ST_WR : ST_RD;
            ST_WR:   if (hbus_ready && last_beat && last_word) state_d = ST_IDLE;
            ST_RD:   if (hbus_valid && last_beat && last_word) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO handshakes and datapath next values
    always_comb begin
        adr_d        = adr_q;
        shift_d      = shift_q;
        asm_d        = asm_q;
        beat_d       = beat_q;
        words_left_d = words_left_q;
        cmd_pop      = 1'b0;
        tx_pop       = 1'b0;
        rx_push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch_c) begin
                    cmd_pop      = 1'b1;
                    adr_d        = head_adr;
                    words_left_d = head_n;
                    beat_d       = BEAT_W'(CYCLES);
                    asm_d        = '0;
                    if (head_we == CMD_WRITE) shift_d = tx_head;
                end
            end
            ST_WR: begin
                if (hbus_ready) begin
                    shift_d = shift_q << HBUS_DATA_WIDTH;
                    beat_d  = beat_q - BEAT_W'(1);
                    if (last_beat) begin
                        tx_pop       = 1'b1;
                        words_left_d = words_left_q - WORDS_W'(1);
                        beat_d       = BEAT_W'(CYCLES);
                        shift_d      = last_word ? '0 : tx_next;
                    end
                end
            end
            ST_RD: begin
                if (hbus_valid) begin
                    asm_d  = (asm_q << HBUS_DATA_WIDTH) | FIFO_DATA_WIDTH'(hbus_dat_i);
                    beat_d = beat_q - BEAT_W'(1);
                    if (last_beat) begin
                        rx_push      = 1'b1;
                        words_left_d = words_left_q - WORDS_W'(1);
                        beat_d       = BEAT_W'(CYCLES);
                    end
                end
            end
            default: ;
        endcase
    end

    // Burst datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q        <= '0;
            shift_q      <= '0;
            asm_q        <= '0;
            beat_q       <= '0;
            words_left_q <= '0;
        end else begin
            adr_q        <= adr_d;
            shift_q      <= shift_d;
            asm_q        <= asm_d;
            beat_q       <= beat_d;
            words_left_q <= words_left_d;
        end
    end

    hyperbus_sync_fifo #(.WIDTH(CMD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid && cmd_ready),
        .data_i  ({cmd_we, cmd_adr, cmd_len}),
        .pop_i   (cmd_pop),
        .data_o  (cmd_head),
        .next_o  (cmd_next),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count)
    );

    hyperbus_sync_fifo #(.WIDTH(FIFO_DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_valid && tx_ready),
        .data_i  (tx_dat),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .next_o  (tx_next),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    hyperbus_sync_fifo #(.WIDTH(FIFO_DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push),
        .data_i  (asm_d),
        .pop_i   (rx_pop),
        .data_o  (rx_dat),
        .next_o  (rx_next),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

endmodule

// File: tb/tb_hyperbus_burst_fifo.sv
// Directed self-checking bench for hyperbus_burst_fifo (default parameters, CYCLES = 2).
module tb_hyperbus_burst_fifo;
    import hyperbus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [2:0]  cmd_len;
    logic        tx_valid, tx_ready;
    logic [31:0] tx_dat;
    logic        rx_valid, rx_ready;
    logic [31:0] rx_dat;
    logic        idle;
    logic [31:0] hbus_adr_o;
    logic [15:0] hbus_dat_i, hbus_dat_o;
    logic        hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hyperbus_burst_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_dat     (tx_dat),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_dat     (rx_dat),
        .idle       (idle),
        .hbus_adr_o (hbus_adr_o),
        .hbus_dat_i (hbus_dat_i),
        .hbus_dat_o (hbus_dat_o),
        .hbus_rrq   (hbus_rrq),
        .hbus_wrq   (hbus_wrq),
        .hbus_ready (hbus_ready),
        .hbus_valid (hbus_valid),
        .hbus_busy  (hbus_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [31:0] d);
        tx_valid = 1'b1;
        tx_dat   = d;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [2:0] len);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for a read request, then return n beats base, base+1, ...
    task automatic serve_read(input int n, input logic [15:0] base, input bit gaps);
        int t = 0;
        while (!hbus_rrq && t < 30) begin
            tick();
            t++;
        end
        check("rd_launch", 32'(hbus_rrq), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 2)) begin
                hbus_valid = 1'b0;
                tick();
            end
            hbus_valid = 1'b1;
            hbus_dat_i = base + 16'(i);
            tick();
        end
        hbus_valid = 1'b0;
        check("rd_done", 32'(hbus_rrq), 32'd0);
    endtask

    task automatic pop_rx(input logic [31:0] exp);
        rx_ready = 1'b1;
        check("rx_valid", 32'(rx_valid), 32'd1);
        check("rx_dat", rx_dat, exp);
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] hi;
        bit          seen;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
        tx_valid = 1'b0; tx_dat = '0; rx_ready = 1'b0;
        hbus_dat_i = '0; hbus_ready = 1'b0; hbus_valid = 1'b0; hbus_busy = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_rrq", 32'(hbus_rrq), 32'd0);
        check("rst_wrq", 32'(hbus_wrq), 32'd0);
        check("rst_adr", hbus_adr_o, 32'h0);
        check("rst_dat", 32'(hbus_dat_o), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;
        tick();

        // Single write, one word, ready tied high
        hbus_ready = 1'b1;
        push_tx(32'hDEADBEEF);
        push_cmd(CMD_WRITE, 32'h100, 3'd0);
        check("w1_pre", 32'(hbus_wrq), 32'd0);
        tick();
        check("w1_wrq0", 32'(hbus_wrq), 32'd1);
        check("w1_adr", hbus_adr_o, 32'h100);
        check("w1_beat0", 32'(hbus_dat_o), 32'hDEAD);
        tick();
        check("w1_wrq1", 32'(hbus_wrq), 32'd1);
        check("w1_beat1", 32'(hbus_dat_o), 32'hBEEF);
        tick();
        check("w1_end", 32'(hbus_wrq), 32'd0);
        check("w1_tx_empty", 32'(dut.u_tx_fifo.count_o), 32'd0);
        check("w1_idle", 32'(idle), 32'd1);

        // Read burst of 4 words with gaps in hbus_valid
        push_cmd(CMD_READ, 32'h200, 3'd3);
        serve_read(8, 16'h0001, 1'b1);
        pop_rx(32'h00010002);
        pop_rx(32'h00030004);
        pop_rx(32'h00050006);
        pop_rx(32'h00070008);
        check("r4_empty", 32'(rx_valid), 32'd0);

        // Write command ahead of its second data word
        push_tx(32'h11112222);
        push_cmd(CMD_WRITE, 32'h300, 3'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (hbus_wrq) seen = 1'b1;
        end
        check("w2_hold", 32'(seen), 32'd0);
        push_tx(32'h33334444);
        check("w2_nolaunch", 32'(hbus_wrq), 32'd0);
        tick();
        begin
            logic [15:0] exp_beats [4];
            exp_beats = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
            for (int j = 0; j < 4; j++) begin
                check("w2_wrq", 32'(hbus_wrq), 32'd1);
                check("w2_beat", 32'(hbus_dat_o), 32'(exp_beats[j]));
                tick();
            end
        end
        check("w2_end", 32'(hbus_wrq), 32'd0);

        // rx backpressure: 6 of 8 entries held, len-3 read must wait
        push_cmd(CMD_READ, 32'h400, 3'd2);
        serve_read(6, 16'h0010, 1'b0);
        push_cmd(CMD_READ, 32'h410, 3'd2);
        serve_read(6, 16'h0020, 1'b0);
        push_cmd(CMD_READ, 32'h420, 3'd3);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (hbus_rrq) seen = 1'b1;
        end
        check("bp_hold", 32'(seen), 32'd0);
        check("bp_idle", 32'(idle), 32'd0);
        pop_rx(32'h00100011);
        pop_rx(32'h00120013);
        serve_read(8, 16'h0030, 1'b0);
        pop_rx(32'h00140015);
        pop_rx(32'h00200021);
        pop_rx(32'h00220023);
        pop_rx(32'h00240025);
        pop_rx(32'h00300031);
        pop_rx(32'h00320033);
        pop_rx(32'h00340035);
        pop_rx(32'h00360037);
        check("bp_empty", 32'(rx_valid), 32'd0);

        // Busy defers launch
        hbus_busy = 1'b1;
        push_tx(32'hCAFEF00D);
        push_cmd(CMD_WRITE, 32'h500, 3'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (hbus_wrq) seen = 1'b1;
        end
        check("busy_hold", 32'(seen), 32'd0);
        hbus_busy = 1'b0;
        tick();
        check("busy_launch", 32'(hbus_wrq), 32'd1);
        check("busy_beat0", 32'(hbus_dat_o), 32'hCAFE);
        tick();
        check("busy_beat1", 32'(hbus_dat_o), 32'hF00D);
        tick();
        check("busy_end", 32'(hbus_wrq), 32'd0);

        // Command FIFO full: 8 accepted, 9th refused
        hbus_busy = 1'b1;
        for (int j = 0; j < 8; j++) push_cmd(CMD_READ, 32'h800 + 32'(j), 3'd0);
        check("cmd_full", 32'(cmd_ready), 32'd0);
        push_cmd(CMD_READ, 32'h900, 3'd0);
        check("cmd_full9", 32'(cmd_ready), 32'd0);
        hbus_busy = 1'b0;
        for (int j = 0; j < 8; j++) serve_read(2, 16'h0040 + 16'(2 * j), 1'b0);
        check("cmd_drained_idle", 32'(idle), 32'd1);
        for (int j = 0; j < 8; j++) begin
            hi = 16'h0040 + 16'(2 * j);
            pop_rx({hi, hi + 16'd1});
        end
        check("cmd_rx_empty", 32'(rx_valid), 32'd0);

        // Reset in the middle of a read burst
        push_cmd(CMD_READ, 32'h600, 3'd1);
        begin
            int t = 0;
            while (!hbus_rrq && t < 30) begin
                tick();
                t++;
            end
        end
        check("mid_rrq", 32'(hbus_rrq), 32'd1);
        hbus_valid = 1'b1;
        hbus_dat_i = 16'hAAAA;
        tick();
        hbus_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rrq", 32'(hbus_rrq), 32'd0);
        check("mid_rst_adr", hbus_adr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_idle", 32'(idle), 32'd1);
        check("post_rx_valid", 32'(rx_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
        push_tx(32'h12345678);
        push_cmd(CMD_WRITE, 32'h700, 3'd0);
        tick();
        check("post_wrq", 32'(hbus_wrq), 32'd1);
        check("post_adr", hbus_adr_o, 32'h700);
        check("post_beat0", 32'(hbus_dat_o), 32'h1234);
        tick();
        check("post_beat1", 32'(hbus_dat_o), 32'h5678);
        tick();
        check("post_end", 32'(hbus_wrq), 32'd0);
        check("post_idle2", 32'(idle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
